// File: rtl/alu_writeback_unit.sv
// rtl/alu_writeback_unit.sv - execute/writeback stage: register-file writes, compare flag, LOAD memory handshake
// Optional load timeout enabled by defining WB_TIMEOUT_EN.
module alu_writeback_unit #(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_W     = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  compare_in,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  cmp_flag,
  output logic                  mem_req,
  output logic [DATA_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  load_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_LOAD_WB  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0]     r_rf_wdata;
  logic                  r_cmp_flag;
  logic                  r_mem_req;
  logic [DATA_W-1:0]     r_mem_addr;
  logic [REG_ADDR_W-1:0] r_ld_rd;

  logic w_accept;
  logic w_is_alu;
  logic w_is_cmp;
  logic w_is_load;
  logic w_wait;
  logic w_timeout;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_alu  = (opcode <= 4'd4);
  assign w_is_cmp  = (opcode == 4'd5);
  assign w_is_load = (opcode == 4'd6);
  assign w_wait    = (r_state == S_MEM_WAIT);

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_load_err;

  // mem_ack is excluded so an acknowledge on the final cycle still completes normally.
  assign w_timeout = w_wait && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign load_err  = r_load_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_timeout;
      if (w_accept && w_is_load) begin
        r_cnt <= '0;
      end else if (w_wait && !mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign load_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_load) begin
          w_next = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          w_next = S_LOAD_WB;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD_WB: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Write address/data only change on a write, so they stay stable between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_cmp_flag <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ld_rd    <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_accept && w_is_alu) begin
        r_rf_we    <= 1'b1;
        r_rf_waddr <= rd_addr;
        r_rf_wdata <= alu_result;
      end
      if (w_accept && w_is_cmp) begin
        r_cmp_flag <= compare_in;
      end
      if (w_accept && w_is_load) begin
        r_mem_addr <= alu_result;
        r_ld_rd    <= rd_addr;
        r_mem_req  <= 1'b1;
      end
      if (w_wait && mem_ack) begin
        r_rf_we    <= 1'b1;
        r_rf_waddr <= r_ld_rd;
        r_rf_wdata <= mem_rdata;
        r_mem_req  <= 1'b0;
      end else if (w_timeout) begin
        r_mem_req  <= 1'b0;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign cmp_flag = r_cmp_flag;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// tb/tb_alu_writeback_unit.sv - directed self-checking bench for alu_writeback_unit
module tb_alu_writeback_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] alu_result;
  logic       compare_in;
  logic [2:0] rd_addr;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       cmp_flag;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       load_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_writeback_unit #(
    .DATA_W(8),
    .REG_ADDR_W(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opcode(opcode),
    .alu_result(alu_result),
    .compare_in(compare_in),
    .rd_addr(rd_addr),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .cmp_flag(cmp_flag),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .load_err(load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] res, input logic [2:0] rd, input logic cmp);
    in_valid   = 1'b1;
    opcode     = op;
    alu_result = res;
    rd_addr    = rd;
    compare_in = cmp;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    opcode     = 4'h0;
    alu_result = 8'h00;
    compare_in = 1'b0;
    rd_addr    = 3'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 8'h00;

    tick();
    tick();
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_cmp_flag", cmp_flag, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_load_err", load_err, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // ADD
    issue(4'h0, 8'h5A, 3'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("add_we", rf_we, 1);
    check("add_waddr", rf_waddr, 3);
    check("add_wdata", rf_wdata, 8'h5A);
    check("add_cmp", cmp_flag, 0);
    tick();
    check("add_we_drop", rf_we, 0);

    // COMPARE then XOR
    issue(4'h5, 8'hEE, 3'd6, 1'b1);
    tick();
    check("cmp_flag_set", cmp_flag, 1);
    check("cmp_no_we", rf_we, 0);
    issue(4'h4, 8'h0F, 3'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("xor_we", rf_we, 1);
    check("xor_waddr", rf_waddr, 1);
    check("xor_wdata", rf_wdata, 8'h0F);
    check("xor_cmp_held", cmp_flag, 1);
    tick();
    check("xor_we_drop", rf_we, 0);
    check("cmp_still_held", cmp_flag, 1);

    // LOAD with ack in the third MEM_WAIT cycle
    issue(4'h6, 8'h20, 3'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ld_req_c1", mem_req, 1);
    check("ld_addr_c1", mem_addr, 8'h20);
    check("ld_rdy_c1", in_ready, 0);
    check("ld_we_c1", rf_we, 0);
    tick();
    check("ld_req_c2", mem_req, 1);
    check("ld_rdy_c2", in_ready, 0);
    tick();
    check("ld_req_c3", mem_req, 1);
    check("ld_addr_c3", mem_addr, 8'h20);
    mem_ack   = 1'b1;
    mem_rdata = 8'hC3;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check("ld_wb_we", rf_we, 1);
    check("ld_wb_waddr", rf_waddr, 5);
    check("ld_wb_wdata", rf_wdata, 8'hC3);
    check("ld_wb_req", mem_req, 0);
    check("ld_wb_rdy", in_ready, 0);
    tick();
    check("ld_done_rdy", in_ready, 1);
    check("ld_done_we", rf_we, 0);

    // back-to-back SUB/AND/OR then unused opcode
    issue(4'h1, 8'h11, 3'd2, 1'b0);
    tick();
    check("sub_we", rf_we, 1);
    check("sub_wdata", rf_wdata, 8'h11);
    check("sub_waddr", rf_waddr, 2);
    issue(4'h2, 8'h22, 3'd4, 1'b0);
    tick();
    check("and_we", rf_we, 1);
    check("and_wdata", rf_wdata, 8'h22);
    check("and_waddr", rf_waddr, 4);
    issue(4'h3, 8'h33, 3'd0, 1'b0);
    tick();
    check("or_we", rf_we, 1);
    check("or_wdata", rf_wdata, 8'h33);
    check("or_waddr", rf_waddr, 0);
    issue(4'hA, 8'h99, 3'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    check("nop_we", rf_we, 0);
    check("nop_wdata_stable", rf_wdata, 8'h33);
    check("nop_cmp", cmp_flag, 1);
    check("nop_rdy", in_ready, 1);

    // stray mem_ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 8'h55;
    tick();
    tick();
    mem_ack = 1'b0;
    check("stray_ack_we", rf_we, 0);
    check("stray_ack_req", mem_req, 0);
    check("stray_ack_rdy", in_ready, 1);

    // reset during MEM_WAIT
    issue(4'h6, 8'h44, 3'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    check("rl_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rl_req_async", mem_req, 0);
    check("rl_cmp_async", cmp_flag, 0);
    tick();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    tick();
    tick();
    mem_ack = 1'b0;
    check("rl_no_we", rf_we, 0);
    check("rl_wdata", rf_wdata, 0);
    check("rl_req_after", mem_req, 0);
    check("rl_rdy", in_ready, 1);

`ifdef WB_TIMEOUT_EN
    begin
      int n_req;
      n_req = 0;
      issue(4'h6, 8'h81, 3'd2, 1'b0);
      tick();
      in_valid = 1'b0;
      while (mem_req && n_req < 40) begin
        check("to_no_err", load_err, 0);
        n_req++;
        tick();
      end
      check("to_req_cycles", n_req, 16);
      check("to_err", load_err, 1);
      check("to_req", mem_req, 0);
      check("to_we", rf_we, 0);
      check("to_rdy", in_ready, 1);
      tick();
      check("to_err_pulse", load_err, 0);
    end
`else
    check("no_to_err", load_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
